// File: rtl/pkt_rx_buffer.sv
// Store-and-forward packet receive buffer: beats are written speculatively into a RAM
// and become visible to the reader only once their eop beat commits a length entry.
module pkt_rx_buffer #(
  parameter int DW          = 32,
  parameter int RAM_ADDR_W  = 5,
  parameter int FIFO_ADDR_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_sop,
  input  logic          i_vld,
  input  logic          i_eop,
  input  logic [DW-1:0] i_data,
  output logic          o_sop,
  output logic          o_vld,
  output logic          o_eop,
  output logic [DW-1:0] o_data,
  input  logic          i_rdy,
  output logic [15:0]   o_pkt_cnt,
  output logic [15:0]   o_drop_cnt,
  output logic [2:0]    dbg_state
);
  localparam int PW = RAM_ADDR_W + 1;
  localparam int FW = FIFO_ADDR_W + 1;
  localparam logic [PW-1:0] RAM_DEPTH  = PW'(1) << RAM_ADDR_W;
  localparam logic [FW-1:0] FIFO_DEPTH = FW'(1) << FIFO_ADDR_W;

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} w_state_t;
  typedef enum logic {R_IDLE, R_PKT} r_state_t;

  w_state_t w_state, w_nxt;
  r_state_t r_state, r_nxt;

  logic [DW-1:0] ram [0:(1<<RAM_ADDR_W)-1];
  logic [DW-1:0] ram_q;
  logic [PW-1:0] fifo_mem [0:(1<<FIFO_ADDR_W)-1];
  logic [PW-1:0] fifo_q;
  logic [FW-1:0] f_wp, f_rp;
  logic          fifo_full, fifo_empty, fifo_pop;

  logic [PW-1:0] wr_ptr, wr_cur, wr_cur_nxt;
  logic [PW-1:0] rd_ptr, rd_ptr_nxt, rd_left;
  logic [RAM_ADDR_W-1:0] ram_wa;
  logic          wr_en, commit, rd_first, xfer;
  logic [1:0]    drop_inc;
  logic [16:0]   drop_sum;

  assign fifo_empty = (f_wp == f_rp);
  assign fifo_full  = ((f_wp - f_rp) == FIFO_DEPTH);
  assign fifo_q     = fifo_mem[f_rp[FIFO_ADDR_W-1:0]];

  // Write FSM. A sop beat always restarts at the committed pointer, which also
  // rolls back any partial packet still open in W_PKT.
  always_comb begin
    w_nxt      = w_state;
    wr_en      = 1'b0;
    commit     = 1'b0;
    drop_inc   = 2'd0;
    wr_cur_nxt = wr_cur;
    ram_wa     = wr_cur[RAM_ADDR_W-1:0];
    if (i_vld) begin
      if (i_sop) begin
        if (w_state == W_PKT) drop_inc = 2'd1;
        ram_wa = wr_ptr[RAM_ADDR_W-1:0];
        if (fifo_full || ((wr_ptr - rd_ptr) == RAM_DEPTH)) begin
          drop_inc   = drop_inc + 2'd1;
          wr_cur_nxt = wr_ptr;
          w_nxt      = i_eop ? W_IDLE : W_DROP;
        end else begin
          wr_en      = 1'b1;
          wr_cur_nxt = wr_ptr + PW'(1);
          commit     = i_eop;
          w_nxt      = i_eop ? W_IDLE : W_PKT;
        end
      end else if (w_state == W_PKT) begin
        if ((wr_cur - rd_ptr) == RAM_DEPTH) begin
          drop_inc   = 2'd1;
          wr_cur_nxt = wr_ptr;
          w_nxt      = i_eop ? W_IDLE : W_DROP;
        end else begin
          wr_en      = 1'b1;
          wr_cur_nxt = wr_cur + PW'(1);
          commit     = i_eop;
          if (i_eop) w_nxt = W_IDLE;
        end
      end else if ((w_state == W_DROP) && i_eop) begin
        w_nxt = W_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      wr_ptr  <= '0;
      wr_cur  <= '0;
    end else begin
      w_state <= w_nxt;
      wr_cur  <= wr_cur_nxt;
      if (commit) wr_ptr <= wr_cur_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ram[ram_wa] <= i_data;
  end

  // Length FIFO; entry = committed length, pushed on commit, popped when a packet starts.
  always_ff @(posedge clk) begin
    if (commit) fifo_mem[f_wp[FIFO_ADDR_W-1:0]] <= wr_cur_nxt - wr_ptr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_wp <= '0;
      f_rp <= '0;
    end else begin
      if (commit)   f_wp <= f_wp + FW'(1);
      if (fifo_pop) f_rp <= f_rp + FW'(1);
    end
  end

  // Downstream handshake: a beat moves when o_vld && i_rdy; while o_vld is high and
  // i_rdy low, o_data/o_sop/o_eop hold. ram_q always holds the word at rd_ptr,
  // because the RAM is addressed with the pointer value for the next cycle.
  assign o_vld      = (r_state == R_PKT);
  assign xfer       = o_vld && i_rdy;
  assign o_sop      = o_vld && rd_first;
  assign o_eop      = o_vld && (rd_left == PW'(1));
  assign o_data     = o_vld ? ram_q : '0;
  assign fifo_pop   = !fifo_empty && ((r_state == R_IDLE) || (xfer && o_eop));
  assign rd_ptr_nxt = xfer ? rd_ptr + PW'(1) : rd_ptr;

  always_comb begin
    r_nxt = r_state;
    if (fifo_pop)           r_nxt = R_PKT;
    else if (xfer && o_eop) r_nxt = R_IDLE;
  end

  always_ff @(posedge clk) begin
    ram_q <= ram[rd_ptr_nxt[RAM_ADDR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= R_IDLE;
      rd_ptr   <= '0;
      rd_left  <= '0;
      rd_first <= 1'b0;
    end else begin
      r_state <= r_nxt;
      rd_ptr  <= rd_ptr_nxt;
      if (fifo_pop) begin
        rd_left  <= fifo_q;
        rd_first <= 1'b1;
      end else if (xfer) begin
        rd_left  <= rd_left - PW'(1);
        rd_first <= 1'b0;
      end
    end
  end

  // A sop beat in W_PKT can both roll back a partial packet and be refused itself.
  assign drop_sum = {1'b0, o_drop_cnt} + {15'd0, drop_inc};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_pkt_cnt  <= '0;
      o_drop_cnt <= '0;
    end else begin
      if (commit && (o_pkt_cnt != 16'hFFFF)) o_pkt_cnt <= o_pkt_cnt + 16'd1;
      o_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign dbg_state = {r_state, w_state};

endmodule

// File: doc/pkt_rx_buffer.md
PKT_RX_BUFFER -- requirements
Module: pkt_rx_buffer

Interface
REQ-001 SHALL have parameter DW, default 32, data word width.
REQ-002 SHALL have parameter RAM_ADDR_W, default 5, packet RAM depth = 2^RAM_ADDR_W words.
REQ-003 SHALL have parameter FIFO_ADDR_W, default 5, length FIFO depth = 2^FIFO_ADDR_W entries.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports i_sop, i_vld, i_eop  input  1  upstream packet stream controls; sop/eop qualified by i_vld.
REQ-007 SHALL have port i_data  input  DW  upstream data word, valid when i_vld=1.
REQ-008 SHALL have ports o_sop, o_vld, o_eop  output  1  downstream packet stream controls.
REQ-009 SHALL have port o_data  output  DW  downstream data word.
REQ-010 SHALL have port i_rdy  input  1  downstream ready; beat transfers when o_vld&&i_rdy.
REQ-011 SHALL have ports o_pkt_cnt, o_drop_cnt  output  16  committed / dropped packet counters.

Function
REQ-012 SHALL accept one input beat per cycle whenever i_vld=1; no input backpressure exists.
REQ-013 SHALL treat i_sop=1 as first beat and i_eop=1 as last beat; sop&&eop = 1-word packet.
REQ-014 SHALL run write FSM W_IDLE/W_PKT/W_DROP: W_IDLE->W_PKT on sop beat (non-eop); W_PKT->W_IDLE on eop beat; any state->W_DROP on overflow.
REQ-015 SHALL write beats to RAM at speculative pointer wr_cur; committed pointer wr_ptr advances to wr_cur+1 only on accepted eop beat.
REQ-016 SHALL on commit push packet length (RAM_ADDR_W+1 bits, 1..2^RAM_ADDR_W) into length FIFO and increment o_pkt_cnt.
REQ-017 SHALL use RAM_ADDR_W+1-bit pointers; RAM full when wr_cur-rd_ptr = 2^RAM_ADDR_W; addresses wrap modulo depth.
REQ-018 SHALL drop packet when a beat arrives with RAM full, or sop arrives with length FIFO full: wr_cur<=wr_ptr, o_drop_cnt+1, enter W_DROP (W_IDLE if that beat has eop).
REQ-019 SHALL in W_DROP discard beats until eop beat, then W_IDLE; a sop beat in W_DROP starts a new packet.
REQ-020 SHALL on sop beat while in W_PKT drop partial packet (rollback, o_drop_cnt+1) and start new packet with that beat.
REQ-021 SHALL silently discard vld beats without sop in W_IDLE (no counter change).
REQ-022 SHALL run read FSM R_IDLE/R_PKT: R_IDLE->R_PKT when length FIFO non-empty (pop length); R_PKT->R_IDLE after eop beat transfers.
REQ-023 SHALL read RAM synchronously (1-cycle) from rd_ptr; rd_ptr only sees committed data (bounded by wr_ptr).
REQ-024 SHALL assert o_sop on first beat, o_eop on last beat of each output packet, both qualified by o_vld.
REQ-025 SHALL hold o_data/o_sop/o_eop stable while o_vld=1&&i_rdy=0.
REQ-026 SHALL present first output beat no later than 3 cycles after the committing eop beat when read side idle and i_rdy=1.
REQ-027 SHALL sustain 1 beat/cycle output within a packet when i_rdy=1.
REQ-028 SHALL permit simultaneous commit and length-FIFO pop, and simultaneous RAM write and read, without loss.
REQ-029 SHALL saturate o_pkt_cnt and o_drop_cnt at 16'hFFFF.
REQ-030 SHALL output packets in commit order with data identical to input.

Reset
REQ-031 SHALL on rst_n=0 clear all pointers, length FIFO, counters; o_sop/o_vld/o_eop=0, o_data=0; FSMs to W_IDLE/R_IDLE.
REQ-032 SHALL on reset mid-packet discard partial input and partial output packets; RAM contents need not clear.

Verification
REQ-033 SHALL verify: 4-word packet 0x1..0x4, i_rdy=1 -> output 0x1..0x4, sop on 0x1, eop on 0x4, o_pkt_cnt=1, first beat <=3 cycles after eop.
REQ-034 SHALL verify: 1-word packet (sop&&eop, 0xA5) -> single output beat, o_sop=o_eop=1, data 0xA5.
REQ-035 SHALL verify: i_rdy=0 with 3 packets of 8 words stored -> o_data held; i_rdy=1 -> 24 beats in order, no gaps.
REQ-036 SHALL verify: 40-word packet, depth 32 -> o_drop_cnt=1, no output, following 2-word packet passes intact.
REQ-037 SHALL verify: sop at beat 3 of in-progress packet -> o_drop_cnt=1, only new packet output.
REQ-038 SHALL verify: rst_n=0 mid output packet -> next cycle o_vld=0, counters 0; new packet afterward outputs correctly.
